// File: rtl/mem_arbiter.sv
// mem_arbiter: one memory port shared by I-fill, D-fill and store traffic.
// Define ARB_RR_EN for round-robin I-miss vs D-miss arbitration.
module mem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int MEM_LAT       = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_miss_req,
  input  logic [ADDR_W-1:0]                i_miss_addr,
  input  logic                             d_miss_req,
  input  logic [ADDR_W-1:0]                d_miss_addr,
  input  logic                             d_wr_req,
  input  logic [ADDR_W-1:0]                d_wr_addr,
  input  logic [DATA_W-1:0]                d_wr_data,
  output logic                             mem_en,
  output logic                             mem_wr,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic [DATA_W-1:0]                mem_rdata,
  input  logic                             mem_rvalid,
  output logic [DATA_W-1:0]                fill_data,
  output logic [$clog2(WORDS_PER_BLK)-1:0] fill_word,
  output logic                             i_fill_we,
  output logic                             d_fill_we,
  output logic                             i_fill_done,
  output logic                             d_fill_done,
  output logic                             d_wr_ack,
  output logic                             busy
);

  localparam int IDX_W = $clog2(WORDS_PER_BLK);
  localparam int OFF_W = IDX_W + 1;
  localparam int CNT_W = IDX_W + 1;
  localparam int BLK_W = ADDR_W - OFF_W;
  localparam logic [CNT_W-1:0] NWORDS = CNT_W'(WORDS_PER_BLK);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WORDS_PER_BLK - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  if (WORDS_PER_BLK < 2 || (WORDS_PER_BLK & (WORDS_PER_BLK - 1)) != 0
      || MEM_LAT < 1) begin : g_bad_cfg
    $error("mem_arbiter: invalid WORDS_PER_BLK or MEM_LAT");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FILL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   ret_cnt_q, ret_cnt_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               fill_req;
  logic               pick_own;
`ifdef ARB_RR_EN
  logic               last_fill_q, last_fill_d;
`endif

  logic unused_offsets;
  assign unused_offsets = ^{i_miss_addr[OFF_W-1:0], d_miss_addr[OFF_W-1:0]};

  // State and datapath registers; reset abandons any fill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_I;
      blk_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
`ifdef ARB_RR_EN
      last_fill_q <= OWN_I;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      blk_q       <= blk_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
`ifdef ARB_RR_EN
      last_fill_q <= last_fill_d;
`endif
    end
  end

  // Choose which cache a fill grant goes to.
  always_comb begin
    fill_req = i_miss_req | d_miss_req;
`ifdef ARB_RR_EN
    if (i_miss_req && d_miss_req) pick_own = ~last_fill_q;
    else                          pick_own = d_miss_req;
`else
    pick_own = d_miss_req ? OWN_D : OWN_I;
`endif
  end

  // Next state, grant latching and fill counters.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    blk_d       = blk_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
`ifdef ARB_RR_EN
    last_fill_d = last_fill_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        priority case (1'b1)
          d_wr_req: begin
            state_d   = S_WRITE;
            wr_addr_d = d_wr_addr;
            wr_data_d = d_wr_data;
          end
          fill_req: begin
            state_d     = S_FILL;
            owner_d     = pick_own;
            blk_d       = pick_own ? d_miss_addr[ADDR_W-1:OFF_W]
                                   : i_miss_addr[ADDR_W-1:OFF_W];
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
`ifdef ARB_RR_EN
            last_fill_d = pick_own;
`endif
          end
          default: ;
        endcase
      end
      S_WRITE: state_d = S_IDLE;
      S_FILL: begin
        if (issue_cnt_q < NWORDS) issue_cnt_d = issue_cnt_q + ONE;
        if (mem_rvalid) begin
          ret_cnt_d = ret_cnt_q + ONE;
          if (ret_cnt_q == LAST) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port, fill strobes and pulses decoded from state.
  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    busy        = (state_q != S_IDLE);
    unique case (state_q)
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = wr_addr_q;
        mem_wdata = wr_data_q;
        d_wr_ack  = 1'b1;
      end
      S_FILL: begin
        if (issue_cnt_q < NWORDS) begin
          mem_en   = 1'b1;
          mem_addr = {blk_q, issue_cnt_q[IDX_W-1:0], 1'b0};
        end
        if (mem_rvalid) begin
          fill_data = mem_rdata;
          fill_word = ret_cnt_q[IDX_W-1:0];
          i_fill_we = (owner_q == OWN_I);
          d_fill_we = (owner_q == OWN_D);
          if (ret_cnt_q == LAST) begin
            i_fill_done = (owner_q == OWN_I);
            d_fill_done = (owner_q == OWN_D);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port main-memory arbiter and cache-fill sequencer for the pipelined WISC core. It shares one memory port between the I-cache miss path, the D-cache miss path and D-side write-through stores. Each miss is turned into an 8-word block fill, and each store into a single-cycle write. It sits between both caches and the 4-cycle-latency memory model, and stalls the pipeline through the requesters' held requests.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS_PER_BLK, 8, words per cache block; must be a power of two
- MEM_LAT, 4, cycles from mem_en read issue to mem_rvalid

- clk  in  1  rising-edge clock; one clock for the whole block
- rst_n  in  1  asynchronous, active-low reset
- i_miss_req  in  1  I-cache fill request, level, held until i_fill_done
- i_miss_addr  in  ADDR_W  I-cache miss address; the block offset is ignored
- d_miss_req  in  1  D-cache fill request, level, held until d_fill_done
- d_miss_addr  in  ADDR_W  D-cache miss address
- d_wr_req  in  1  write-through store request, level, held until d_wr_ack
- d_wr_addr  in  ADDR_W  store address
- d_wr_data  in  DATA_W  store data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  1 = write, 0 = read; qualified by mem_en
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data
- mem_rvalid  in  1  read data valid
- fill_data  out  DATA_W  fill word, passed through from mem_rdata
- fill_word  out  log2(WORDS_PER_BLK)  index of the fill word
- i_fill_we  out  1  write strobe into the I-cache data array
- d_fill_we  out  1  write strobe into the D-cache data array
- i_fill_done  out  1  one-cycle pulse on the last I-fill word
- d_fill_done  out  1  one-cycle pulse on the last D-fill word
- d_wr_ack  out  1  one-cycle pulse when the store is issued
- busy  out  1  high when the state is not IDLE

## Operation
- The FSM has three states: IDLE, WRITE and FILL. A 1-bit owner register (I/D) records which cache a fill belongs to.
- IDLE arbitration uses fixed priority: d_wr_req, then d_miss_req, then i_miss_req. Stores win so that memory is always current before any fill reads it.
- IDLE to WRITE: latch d_wr_addr and d_wr_data.
- IDLE to FILL: latch the block base, which is addr[ADDR_W-1:log2(2*WORDS_PER_BLK)] with the offset zeroed. Set the owner, and clear issue_cnt and ret_cnt.
- WRITE:
  - Drive mem_en=1, mem_wr=1, mem_addr and mem_wdata from the latched values.
  - d_wr_ack=1 in the same cycle.
  - Always lasts exactly 1 cycle, then returns to IDLE.
- FILL issue side:
  - While issue_cnt < WORDS_PER_BLK, drive mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
  - issue_cnt increments every cycle, so issue is back-to-back with no bubbles.
- FILL return side:
  - On each mem_rvalid, drive fill_word=ret_cnt and fill_data=mem_rdata.
  - Assert the owner's fill_we; ret_cnt increments.
  - When ret_cnt = WORDS_PER_BLK-1 and mem_rvalid is high, pulse the owner's fill_done and go to IDLE.
- mem_rvalid is ignored outside FILL.
- Width rules:
  - issue_cnt and ret_cnt are log2(WORDS_PER_BLK)+1 bits wide.
  - The address add does not carry into the base; the block never crosses an alignment boundary.
- Reset, asynchronous and valid at any time including mid-fill:
  - State goes to IDLE and all counters clear.
  - Every output is 0: mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, all strobes and pulses, and busy.
  - A partial fill is abandoned, and the requester re-requests after reset.

## Timing
- Requests are sampled at the rising edge only while in IDLE. A request raised during WRITE or FILL waits.
- Fill, with the request high in IDLE cycle T:
  - Word k is issued in cycle T+1+k and returned in cycle T+1+k+MEM_LAT.
  - fill_done occurs in cycle T+WORDS_PER_BLK+MEM_LAT, which is T+12 at the defaults.
  - The FSM is in IDLE at T+13, so the next grant's first issue is at T+14.
- Store, with d_wr_req high in cycle T: mem_en and d_wr_ack are high in cycle T+1, and the FSM is in IDLE at T+2.
- Requesters must drop their request in the cycle after their done or ack pulse. A request still high in IDLE is treated as a new request.
- fill_we and fill_data are combinational from mem_rvalid and mem_rdata. All other outputs are registered or decoded from state.
- Simultaneous requests in IDLE: exactly one is granted. Losers wait with no loss, at worst 1 + (8+MEM_LAT) cycles per intervening grant.

## Configuration
- ARB_RR_EN defined: I-miss versus D-miss arbitration becomes round-robin.
  - A last_fill register, reset to I, records the previous fill owner.
  - When both misses are pending, the non-last owner wins.
  - d_wr_req still has top priority.
- ARB_RR_EN undefined: fixed priority of d_wr, then d_miss, then i_miss, and no last_fill register.

## Test plan
- Reset mid-fill: i_miss_req with addr 0x1236, then rst_n=0 at the 3rd issue cycle. Required: all outputs 0 immediately, and a fresh i_miss_req restarts the fill from word 0 at address 0x1230.
- Single I-fill: i_miss_req with addr 0x1236 at T. Required: mem_addr 0x1230..0x123E in T+1..T+8; i_fill_we with fill_word 0..7 in T+5..T+12; i_fill_done at T+12; d_fill_we never asserted.
- Store: d_wr_req with addr 0x0040 and data 0xBEEF. Required: one cycle of mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, and d_wr_ack in the same cycle.
- Simultaneous d_wr_req, d_miss_req and i_miss_req. Required: store first, then the D-fill, then the I-fill. With ARB_RR_EN and last_fill=D, the I-fill goes ahead of the D-fill instead.
- Stray mem_rvalid=1 in IDLE with data 0x5555. Required: no fill_we and no state change.
